// File: rtl/stack_prog_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the program loader.
// Signal names match the loader's external contract; clock and reset stay outside.
interface stack_prog_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [11:0] imem_data;
    logic        core_run;
    logic        done;
    logic        err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_data, core_run, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_data, core_run, done, err
    );
endinterface

// File: rtl/stack_prog_loader.sv
// Loads a checksummed byte stream (count, {operand, opcode} pairs, checksum) into
// instruction memory, then enables the stack core only if the whole image is good.
module stack_prog_loader #(
    parameter int OPC_MAX = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,   // active-high despite the name
    stack_prog_loader_if.slave bus
);
    localparam int             TW      = $clog2(TIMEOUT + 1);
    localparam logic [3:0]     OPC_LIM = 4'(OPC_MAX);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, HDR, OPND, OPC, WR, CHK, DONE, ERR} state_t;

    state_t        r_state;
    logic [7:0]    r_count;
    logic [7:0]    r_index;
    logic [7:0]    r_opnd;
    logic [7:0]    r_sum;
    logic [7:0]    r_addr;
    logic [11:0]   r_data;
    logic          r_we;
    logic [TW-1:0] r_idle;

    logic w_rdy;
    logic w_acc;
    logic w_opc_ok;

    assign w_rdy    = (r_state == HDR) || (r_state == OPND) || (r_state == OPC) || (r_state == CHK);
    assign w_acc    = bus.in_valid & w_rdy;
    assign w_opc_ok = (bus.in_data[7:4] == 4'd0) && (bus.in_data[3:0] <= OPC_LIM);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_index <= '0;
            r_opnd  <= '0;
            r_sum   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_idle  <= '0;
        end else begin
            r_we <= 1'b0;
            // Idle watchdog; a byte arriving on the last cycle still rescues the load.
            if (w_rdy) begin
                if (w_acc) begin
                    r_idle <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                    if (r_idle == TO_LAST) r_state <= ERR;
                end
            end
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        r_state <= HDR;
                        r_idle  <= '0;
                    end
                end
                HDR: begin
                    if (w_acc) begin
                        r_count <= bus.in_data;
                        r_index <= '0;
                        r_sum   <= bus.in_data;
                        r_state <= OPND;
                    end
                end
                OPND: begin
                    if (w_acc) begin
                        r_opnd  <= bus.in_data;
                        r_sum   <= r_sum + bus.in_data;
                        r_state <= OPC;
                    end
                end
                OPC: begin
                    if (w_acc) begin
                        if (w_opc_ok) begin
                            // Address/data move together with the strobe so they are stable otherwise.
                            r_we    <= 1'b1;
                            r_addr  <= r_index;
                            r_data  <= {r_opnd, bus.in_data[3:0]};
                            r_sum   <= r_sum + bus.in_data;
                            r_state <= WR;
                        end else begin
                            r_state <= ERR;
                        end
                    end
                end
                WR: begin
                    // Count 0 means 256 words, so the last index is count-1 modulo 256.
                    if (r_index == r_count - 8'd1) begin
                        r_state <= CHK;
                    end else begin
                        r_index <= r_index + 8'd1;
                        r_state <= OPND;
                    end
                end
                CHK: begin
                    if (w_acc) r_state <= (bus.in_data == r_sum) ? DONE : ERR;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_rdy;
    assign bus.imem_we   = r_we;
    assign bus.imem_addr = r_addr;
    assign bus.imem_data = r_data;
    assign bus.core_run  = (r_state == DONE);
    assign bus.done      = (r_state == DONE);
    assign bus.err       = (r_state == ERR);
endmodule
